// File: rtl/alu_arith_seq.sv
// ============================================================================
//  Module      : alu_arith_seq
//  Description : Multi-cycle unsigned arithmetic unit (add, sub, mul, div)
//                with a start/busy/done handshake. Multiply is an iterative
//                LSB-first shift-add engine, divide is an iterative
//                restoring engine, one iteration per clock.
//  Ports       :
//      clk        - rising-edge clock
//      rst_n      - asynchronous active-low reset
//      start      - request, sampled only while busy=0
//      opcode     - 000 add, 001 sub, 010 mul, 011 div, 1xx invalid
//      A, B       - operands, captured on an accepted start
//      carry_in   - carry (add) / borrow-in (sub), ignored by mul/div
//      busy       - operation in progress
//      done       - one-cycle pulse, outputs valid
//      result     - sum, difference, low product or quotient
//      left_over  - 0 (add/sub), high product (mul), remainder (div)
//      carry_out  - add carry, sub borrow, mul overflow, 0 for div
//      error      - divide-by-zero or invalid opcode, valid with done
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module alu_arith_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] left_over,
    output logic             carry_out,
    output logic             error
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_cin;
    // Mul: {high partial product, multiplier being shifted out}.
    // Div: low half holds the dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0]   r_acc;
    // Partial remainder of the restoring divider.
    logic [WIDTH:0]       r_rem;

    // ------------------------------------------------------------------
    // Single-cycle add / subtract on the captured operands
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;

    assign w_add = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    // The difference lies in [-2^WIDTH, 2^WIDTH-1], so bit WIDTH of the
    // WIDTH+1-bit result is set exactly when A < B + carry_in.
    assign w_sub = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};

    // ------------------------------------------------------------------
    // Shift-add multiply step
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits.
    // ------------------------------------------------------------------
    logic [WIDTH+1:0]     w_trial;
    logic                 w_ge;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_rem_next;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_trial    = {r_rem, r_acc[WIDTH-1]};
    assign w_ge       = (w_trial >= {2'b00, r_b});
    assign w_diff     = w_trial[WIDTH:0] - {1'b0, r_b};
    assign w_rem_next = w_ge ? w_diff : w_trial[WIDTH:0];
    assign w_div_next = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_acc     <= '0;
            r_rem     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            left_over <= '0;
            carry_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= opcode;
                        r_a   <= A;
                        r_b   <= B;
                        r_cin <= carry_in;
                        r_acc <= {{WIDTH{1'b0}}, A};
                        r_rem <= '0;
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if ((opcode == c_OP_MUL) ||
                            ((opcode == c_OP_DIV) && (B != '0))) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end

                S_RUN: begin
                    if (r_op == c_OP_MUL) begin
                        r_acc <= w_mul_next;
                    end else begin
                        r_acc <= w_div_next;
                        r_rem <= w_rem_next;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                    end
                end

                S_FIN: begin
                    case (r_op)
                        c_OP_ADD: begin
                            result    <= w_add[WIDTH-1:0];
                            left_over <= '0;
                            carry_out <= w_add[WIDTH];
                            error     <= 1'b0;
                        end
                        c_OP_SUB: begin
                            result    <= w_sub[WIDTH-1:0];
                            left_over <= '0;
                            carry_out <= w_sub[WIDTH];
                            error     <= 1'b0;
                        end
                        c_OP_MUL: begin
                            result    <= r_acc[WIDTH-1:0];
                            left_over <= r_acc[2*WIDTH-1:WIDTH];
                            carry_out <= |r_acc[2*WIDTH-1:WIDTH];
                            error     <= 1'b0;
                        end
                        c_OP_DIV: begin
                            // A zero divisor bypasses RUN, so r_acc still
                            // holds the dividend and is not used here.
                            if (r_b == '0) begin
                                result    <= {WIDTH{1'b1}};
                                left_over <= r_a;
                                error     <= 1'b1;
                            end else begin
                                result    <= r_acc[WIDTH-1:0];
                                left_over <= r_rem[WIDTH-1:0];
                                error     <= 1'b0;
                            end
                            carry_out <= 1'b0;
                        end
                        default: begin
                            result    <= '0;
                            left_over <= '0;
                            carry_out <= 1'b0;
                            error     <= 1'b1;
                        end
                    endcase
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arith_seq.sv
// ============================================================================
//  Module      : tb_alu_arith_seq
//  Description : Directed self-checking bench for alu_arith_seq. Two
//                instances (WIDTH=4 and WIDTH=8) share clock and reset;
//                every comparison carries a hand-computed expected value.
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_alu_arith_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       s4 = 1'b0;
    logic [2:0] op4 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       c4 = 1'b0;
    logic       busy4, done4, co4, err4;
    logic [3:0] res4, lo4;

    // WIDTH=8 instance
    logic       s8 = 1'b0;
    logic [2:0] op8 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8, done8, co8, err8;
    logic [7:0] res8, lo8;

    int tests = 0;
    int fails = 0;
    int n;

    alu_arith_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .opcode(op4),
        .A(a4), .B(b4), .carry_in(c4),
        .busy(busy4), .done(done4), .result(res4), .left_over(lo4),
        .carry_out(co4), .error(err4)
    );

    alu_arith_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .opcode(op8),
        .A(a8), .B(b8), .carry_in(c8),
        .busy(busy8), .done(done8), .result(res8), .left_over(lo8),
        .carry_out(co8), .error(err8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits on the falling edge until done rises, counting edges; bounded.
    task automatic wait_done(input bit w8, inout int cnt);
        while (!(w8 ? done8 : done4) && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Issues one request, returns the number of edges after the start edge
    // at which done was first seen.
    task automatic run_op(input bit w8, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, output int cnt);
        @(negedge clk);
        if (w8) begin
            s8 = 1'b1; op8 = op; a8 = a; b8 = b; c8 = cin;
        end else begin
            s4 = 1'b1; op4 = op; a4 = a[3:0]; b4 = b[3:0]; c4 = cin;
        end
        @(negedge clk);
        s4 = 1'b0;
        s8 = 1'b0;
        check("busy_after_accept", {31'b0, (w8 ? busy8 : busy4)}, 32'd1);
        cnt = 0;
        wait_done(w8, cnt);
    endtask

    task automatic chk(input string tag, input bit w8, input logic [7:0] er,
                       input logic [7:0] elo, input logic eco, input logic eerr,
                       input int cnt, input int ecnt);
        check({tag, "_latency"}, cnt, ecnt);
        check({tag, "_done"}, {31'b0, (w8 ? done8 : done4)}, 32'd1);
        check({tag, "_busy"}, {31'b0, (w8 ? busy8 : busy4)}, 32'd0);
        check({tag, "_result"}, w8 ? {24'b0, res8} : {28'b0, res4}, {24'b0, er});
        check({tag, "_left_over"}, w8 ? {24'b0, lo8} : {28'b0, lo4}, {24'b0, elo});
        check({tag, "_carry_out"}, {31'b0, (w8 ? co8 : co4)}, {31'b0, eco});
        check({tag, "_error"}, {31'b0, (w8 ? err8 : err4)}, {31'b0, eerr});
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_busy4", {31'b0, busy4}, 32'd0);
        check("rst_done4", {31'b0, done4}, 32'd0);
        check("rst_result4", {28'b0, res4}, 32'd0);
        check("rst_left_over4", {28'b0, lo4}, 32'd0);
        check("rst_cout_err8", {30'b0, co8, err8}, 32'd0);
        rst_n = 1'b1;

        // ---------------- add ----------------
        run_op(1'b0, 3'b000, 8'h0A, 8'h05, 1'b0, n);
        chk("add4_c0", 1'b0, 8'hF, 8'h0, 1'b0, 1'b0, n, 1);
        run_op(1'b0, 3'b000, 8'h0A, 8'h05, 1'b1, n);
        chk("add4_c1", 1'b0, 8'h0, 8'h0, 1'b1, 1'b0, n, 1);
        // outputs hold after done falls
        @(negedge clk);
        check("hold_done", {31'b0, done4}, 32'd0);
        check("hold_cout", {31'b0, co4}, 32'd1);

        // ---------------- sub ----------------
        run_op(1'b0, 3'b001, 8'h0A, 8'h05, 1'b0, n);
        chk("sub4_pos", 1'b0, 8'h5, 8'h0, 1'b0, 1'b0, n, 1);
        run_op(1'b0, 3'b001, 8'h05, 8'h0A, 1'b0, n);
        chk("sub4_neg", 1'b0, 8'hB, 8'h0, 1'b1, 1'b0, n, 1);

        // ---------------- mul ----------------
        run_op(1'b0, 3'b010, 8'h0A, 8'h05, 1'b0, n);
        chk("mul4", 1'b0, 8'h2, 8'h3, 1'b1, 1'b0, n, 5);
        run_op(1'b1, 3'b010, 8'd200, 8'd200, 1'b0, n);
        chk("mul8", 1'b1, 8'h40, 8'h9C, 1'b1, 1'b0, n, 9);

        // ---------------- div ----------------
        run_op(1'b0, 3'b011, 8'h0A, 8'h05, 1'b0, n);
        chk("div4", 1'b0, 8'h2, 8'h0, 1'b0, 1'b0, n, 5);
        run_op(1'b0, 3'b011, 8'h0A, 8'h00, 1'b0, n);
        chk("div4_by0", 1'b0, 8'hF, 8'hA, 1'b0, 1'b1, n, 1);
        run_op(1'b0, 3'b101, 8'h0A, 8'h05, 1'b1, n);
        chk("invalid_op", 1'b0, 8'h0, 8'h0, 1'b0, 1'b1, n, 1);

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        s4 = 1'b1; op4 = 3'b010; a4 = 4'b1010; b4 = 4'b0101; c4 = 1'b0;
        @(negedge clk);                 // after edge 0
        s4 = 1'b0;
        n = 0;
        @(negedge clk);                 // after edge 1
        n = 1;
        s4 = 1'b1; op4 = 3'b000; a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        @(negedge clk);                 // after edge 2
        n = 2;
        s4 = 1'b0;
        wait_done(1'b0, n);
        chk("mul4_ignore", 1'b0, 8'h2, 8'h3, 1'b1, 1'b0, n, 5);

        // ---------------- start in the done cycle ----------------
        s4 = 1'b1; op4 = 3'b000; a4 = 4'd3; b4 = 4'd4; c4 = 1'b0;
        @(negedge clk);
        s4 = 1'b0;
        check("b2b_busy", {31'b0, busy4}, 32'd1);
        check("b2b_done_low", {31'b0, done4}, 32'd0);
        n = 0;
        wait_done(1'b0, n);
        chk("b2b_add", 1'b0, 8'h7, 8'h0, 1'b0, 1'b0, n, 1);

        // ---------------- async reset mid-RUN ----------------
        @(negedge clk);
        s8 = 1'b1; op8 = 3'b010; a8 = 8'd200; b8 = 8'd200; c8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy8}, 32'd0);
        check("arst_done", {31'b0, done8}, 32'd0);
        check("arst_result", {24'b0, res8}, 32'd0);
        check("arst_left_over", {24'b0, lo8}, 32'd0);
        check("arst_cout_err", {30'b0, co8, err8}, 32'd0);
        repeat (12) @(negedge clk);
        check("arst_no_done", {30'b0, done8, busy8}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_no_done", {30'b0, done8, busy8}, 32'd0);
        run_op(1'b1, 3'b000, 8'd200, 8'd100, 1'b0, n);
        chk("post_rst_add8", 1'b1, 8'h2C, 8'h00, 1'b1, 1'b0, n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arith_seq.md
Name: alu_arith_seq

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational arithmetic ALU.
- Same op set: add, subtract, multiply, divide. Same result/left_over/carry_out semantics.
- Generalised to WIDTH bits, with a start/busy/done handshake.
- Multiply is an iterative shift-add engine; divide is an iterative restoring engine, so area stays constant as WIDTH grows. Sits between the register file and the writeback mux.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- opcode  input  3  000 add, 001 sub, 010 mul, 011 div, others invalid
- A  input  WIDTH  operand A (captured on accepted start)
- B  input  WIDTH  operand B (captured on accepted start)
- carry_in  input  1  carry for add, borrow-in for sub; ignored by mul/div
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; outputs valid
- result  output  WIDTH  sum, difference, low product or quotient
- left_over  output  WIDTH  0 for add/sub, high product for mul, remainder for div
- carry_out  output  1  add carry, sub borrow, mul overflow (high half nonzero), 0 for div
- error  output  1  divide-by-zero or invalid opcode; valid with done

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy, done, error, carry_out = 0; result, left_over = 0; counter = 0.
  - Takes effect immediately, including mid-operation. Any in-flight op is discarded and no done is issued.
- FSM states: IDLE, RUN, FIN.
- Start acceptance: start=1 while busy=0 captures opcode, A, B and carry_in at that edge (edge 0).
  - Add, sub, invalid opcode, and div with B=0 go to FIN.
  - Mul and div with B≠0 go to RUN with counter=0.
- RUN: one iteration per cycle for WIDTH cycles (edges 1..WIDTH); then go to FIN.
  - mul: LSB-first shift-add into a 2*WIDTH accumulator.
  - div: restoring, MSB-first; remainder register WIDTH+1 bits.
- FIN: results registered; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency from the start edge to the done cycle:
  - add/sub/invalid/div-by-zero: done is high in the cycle after edge 1.
  - mul/div: done is high after edge WIDTH+1.
- busy: 1 from edge 0 until the edge that raises done.
- Hold: result, left_over, carry_out and error hold their values until the next accepted start completes. They do not clear on done falling.
- add: {carry_out,result} = A + B + carry_in, width WIDTH+1; left_over = 0.
- sub: result = (A - B - carry_in) mod 2^WIDTH; carry_out = 1 iff A < B + carry_in; left_over = 0.
- mul: unsigned. {left_over,result} = A*B; carry_out = |left_over.
- div: unsigned. result = A/B; left_over = A%B; carry_out = 0.
- div with B=0: result = all ones; left_over = A; carry_out = 0; error = 1.
- Invalid opcode (1xx): result = 0; left_over = 0; carry_out = 0; error = 1.
- error is 0 for all valid completions.
- start while busy=1: ignored, no queuing; captured operands are unaffected.
- start high in the done cycle: accepted, because busy=0 in that cycle. Back-to-back throughput is therefore one op per latency+1 cycles.
- Changes on A, B, opcode or carry_in after capture have no effect on the running op.

Test Plan:
- WIDTH=4, A=1010, B=0101, cin=0, op=000 -> done one cycle after start; result=1111, left_over=0000, cout=0. Repeat with cin=1 -> result=0000, cout=1.
- WIDTH=4, same A/B, op=001 -> result=0101, cout=0. Then A=0101, B=1010 -> result=1011, cout=1.
- WIDTH=4, same A/B, op=010 -> busy for 5 edges; done after edge 5; result=0010, left_over=0011, cout=1. WIDTH=8, A=200, B=200 -> result=0x40, left_over=0x9C, cout=1, done after edge 9.
- WIDTH=4, op=011, A=1010, B=0101 -> result=0010, left_over=0000, error=0. Then B=0000 -> done after edge 1; result=1111, left_over=1010, error=1. Then op=101 -> error=1, result=0000.
- Start mul, pulse start with op=000 at edge 2 -> ignored, mul completes correctly. Then assert start in the done cycle -> next op accepted, busy stays 1.
- Start WIDTH=8 mul, drop rst_n mid-RUN (not on an edge) -> busy, done and all outputs go to 0 immediately. After release, a new add completes normally.
